// File: rtl/or_bitwise_n_bit_unit.sv
// N-bit bitwise OR with a combinational result and a registered, valid-tracked result.
// Optional registered zero/ones flags are enabled by defining OR_BITWISE_FLAGS_EN.
module or_bitwise_n_bit_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic [N-1:0] out_q,
  output logic         out_q_valid
`ifdef OR_BITWISE_FLAGS_EN
  ,
  output logic         zero_q,
  output logic         ones_q
`endif
);

  logic [N-1:0] res;
  logic [N-1:0] res_d;
  logic [N-1:0] res_q;
  logic         vld_d;
  logic         vld_q;

  assign res = in_a | in_b;
  assign out = res;

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    if (in_valid) begin
      res_d = res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign out_q       = res_q;
  assign out_q_valid = vld_q;

`ifdef OR_BITWISE_FLAGS_EN
  logic zero_d;
  logic zero_fq;
  logic ones_d;
  logic ones_fq;

  // Flags follow the same capture/hold rule as the result register.
  always_comb begin
    zero_d = zero_fq;
    ones_d = ones_fq;
    if (in_valid) begin
      zero_d = (res == '0);
      ones_d = &res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_fq <= 1'b0;
      ones_fq <= 1'b0;
    end else begin
      zero_fq <= zero_d;
      ones_fq <= ones_d;
    end
  end

  assign zero_q = zero_fq;
  assign ones_q = ones_fq;
`endif

endmodule

// File: tb/tb_or_bitwise_n_bit_unit.sv
// Self-checking bench for or_bitwise_n_bit_unit at N=8, N=1 and N=32.
// Flag checks are compiled in when OR_BITWISE_FLAGS_EN is defined.
module tb_or_bitwise_n_bit_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0, o8, q8;
  logic        v8 = 1'b0, qv8;
  logic [0:0]  a1 = '0, b1 = '0, o1, q1;
  logic        v1 = 1'b0, qv1;
  logic [31:0] a32 = '0, b32 = '0, o32, q32;
  logic        v32 = 1'b0, qv32;
`ifdef OR_BITWISE_FLAGS_EN
  logic z8, n8, z1, n1, z32, n32;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  or_bitwise_n_bit_unit #(.N(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_a(a8), .in_b(b8),
    .in_valid(v8), .out(o8), .out_q(q8), .out_q_valid(qv8)
`ifdef OR_BITWISE_FLAGS_EN
    , .zero_q(z8), .ones_q(n8)
`endif
  );

  or_bitwise_n_bit_unit #(.N(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_a(a1), .in_b(b1),
    .in_valid(v1), .out(o1), .out_q(q1), .out_q_valid(qv1)
`ifdef OR_BITWISE_FLAGS_EN
    , .zero_q(z1), .ones_q(n1)
`endif
  );

  or_bitwise_n_bit_unit #(.N(32)) u32 (
    .clk(clk), .reset_n(reset_n), .in_a(a32), .in_b(b32),
    .in_valid(v32), .out(o32), .out_q(q32), .out_q_valid(qv32)
`ifdef OR_BITWISE_FLAGS_EN
    , .zero_q(z32), .ones_q(n32)
`endif
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference OR via the arithmetic identity a|b = a + b - (a&b).
  function automatic longint unsigned ref_or(input longint unsigned a,
                                             input longint unsigned b);
    return a + b - (a & b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } comb_vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [7:0] exp_q;
    logic       exp_qv;
  } reg_vec_t;

  comb_vec_t cv[5];
  reg_vec_t  rv[6];

  initial begin
    longint unsigned m1_q, m32_q;
    logic m1_v, m32_v;

    cv[0] = '{8'h01, 8'h00, 8'h01};
    cv[1] = '{8'h01, 8'h01, 8'h01};
    cv[2] = '{8'h03, 8'h04, 8'h07};
    cv[3] = '{8'h0F, 8'h0F, 8'h0F};
    cv[4] = '{8'hF0, 8'h0F, 8'hFF};

    rv[0] = '{8'h03, 8'h04, 1'b1, 8'h07, 1'b1};
    rv[1] = '{8'hAA, 8'h55, 1'b0, 8'h07, 1'b0};
    rv[2] = '{8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b1};
    rv[3] = '{8'h10, 8'h01, 1'b1, 8'h11, 1'b1};
    rv[4] = '{8'h00, 8'h00, 1'b0, 8'h11, 1'b0};
    rv[5] = '{8'h80, 8'h00, 1'b1, 8'h80, 1'b1};

    #3;
    check("reset_out", o8, 8'h00);
    check("reset_out_q", q8, 8'h00);
    check("reset_out_q_valid", qv8, 1'b0);
`ifdef OR_BITWISE_FLAGS_EN
    check("reset_zero_q", z8, 1'b0);
    check("reset_ones_q", n8, 1'b0);
`endif

    for (int i = 0; i < 5; i++) begin
      a8 = cv[i].a;
      b8 = cv[i].b;
      #1;
      check($sformatf("comb_%0d", i), o8, ref_or(cv[i].a, cv[i].b));
      check($sformatf("comb_tbl_%0d", i), o8, cv[i].exp);
    end
    check("reset_hold_q", q8, 8'h00);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      a8 = rv[i].a;
      b8 = rv[i].b;
      v8 = rv[i].v;
      tick();
      check($sformatf("reg_q_%0d", i), q8, rv[i].exp_q);
      check($sformatf("reg_qv_%0d", i), qv8, rv[i].exp_qv);
    end

    a8 = 8'hF0; b8 = 8'h0F; v8 = 1'b1;
    tick();
    check("pre_areset_q", q8, 8'hFF);
    v8 = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_q", q8, 8'h00);
    check("areset_qv", qv8, 1'b0);
`ifdef OR_BITWISE_FLAGS_EN
    check("areset_zero", z8, 1'b0);
    check("areset_ones", n8, 1'b0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    a8 = 8'h03; b8 = 8'h04; v8 = 1'b1;
    tick();
    check("post_reset_q", q8, 8'h07);
    check("post_reset_qv", qv8, 1'b1);

`ifdef OR_BITWISE_FLAGS_EN
    a8 = 8'h00; b8 = 8'h00; v8 = 1'b1;
    tick();
    check("flag_zero_z", z8, 1'b1);
    check("flag_zero_o", n8, 1'b0);
    a8 = 8'hF0; b8 = 8'h0F;
    tick();
    check("flag_ones_z", z8, 1'b0);
    check("flag_ones_o", n8, 1'b1);
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    tick();
    check("flag_hold_o", n8, 1'b1);
    a8 = 8'h03; b8 = 8'h04; v8 = 1'b1;
    tick();
    check("flag_mid_z", z8, 1'b0);
    check("flag_mid_o", n8, 1'b0);
`endif
    v8 = 1'b0;

    m1_q = 0; m1_v = 1'b0;
    m32_q = 0; m32_v = 1'b0;
    check("sweep_init_q1", q1, m1_q);
    check("sweep_init_q32", q32, m32_q);
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      v1 = 1'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      v32 = 1'($urandom);
      #1;
      check("sweep_out1", o1, ref_or(a1, b1));
      check("sweep_out32", o32, ref_or(a32, b32));
      m1_v = v1;
      if (v1) m1_q = ref_or(a1, b1);
      m32_v = v32;
      if (v32) m32_q = ref_or(a32, b32);
      tick();
      check("sweep_q1", q1, m1_q);
      check("sweep_qv1", qv1, m1_v);
      check("sweep_q32", q32, m32_q);
      check("sweep_qv32", qv32, m32_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
